// File: rtl/uart_echo_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_echo_pkg: shared TX state encoding, baud table and lookup helper    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package uart_echo_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  // Clocks per bit, rounded to nearest: 10417, 5208, 2604, 1302.
  localparam logic [13:0] BAUD_4800  = 14'((CLK_FREQ_HZ + 2400) / 4800);
  localparam logic [13:0] BAUD_9600  = 14'((CLK_FREQ_HZ + 4800) / 9600);
  localparam logic [13:0] BAUD_19200 = 14'((CLK_FREQ_HZ + 9600) / 19200);
  localparam logic [13:0] BAUD_38400 = 14'((CLK_FREQ_HZ + 19200) / 38400);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_ARM   = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_t;

  function automatic logic [13:0] baud_lookup(input logic [1:0] sel);
    logic [13:0] val;
    unique case (sel)
      2'd0:    val = BAUD_4800;
      2'd1:    val = BAUD_9600;
      2'd2:    val = BAUD_19200;
      default: val = BAUD_38400;
    endcase
    return val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_echo_fifo.sv
// +--------------------------------------------------------------------------+
// | uart_echo_fifo: synchronous byte FIFO, push accepted when full if popped |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_echo_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_echo_driver.sv
// +--------------------------------------------------------------------------+
// | uart_echo_driver: UART byte echo loop (RX -> FIFO -> TX) and baud select |
// | Optional UART_ECHO_CASE_EN: upper-case a..z on the push path. Rev 1.0    |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_echo_driver
  import uart_echo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          rx_rdy,
  input  logic [7:0]                    rx_data,
  output logic                          clr_rx_rdy,
  output logic                          trmt,
  output logic [7:0]                    tx_data,
  input  logic                          tx_done,
  output logic [13:0]                   baud_goal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);

  tx_state_t   state_q, state_d;
  logic        clr_q;
  logic [7:0]  rx_byte_q;
  logic [7:0]  rx_byte;
  logic        rx_take;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [7:0]  tx_data_q;
  logic [13:0] baud_q;
  logic        overflow_q;

`ifdef UART_ECHO_CASE_EN
  assign rx_byte = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? (rx_data - 8'h20) : rx_data;
`else
  assign rx_byte = rx_data;
`endif

  // The ack register doubles as the push strobe; it also blocks a second
  // capture while the receiver is still dropping rdy.
  assign rx_take = rx_rdy && !clr_q;
  assign pop     = (state_q == TX_IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q     <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      clr_q <= rx_take;
      if (rx_take) rx_byte_q <= rx_byte;
    end
  end

  uart_echo_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (clr_q),
    .pop   (pop),
    .din   (rx_byte_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:  if (!fifo_empty) state_d = TX_START;
      TX_START: state_d = TX_ARM;
      TX_ARM:   if (!tx_done) state_d = TX_WAIT;
      TX_WAIT:  if (tx_done) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= 8'h00;
      baud_q     <= BAUD_9600;
      overflow_q <= 1'b0;
    end else begin
      if (pop) tx_data_q <= fifo_dout;
      // Rate only changes when nothing is queued or on the wire.
      if (state_q == TX_IDLE && fifo_empty) baud_q <= baud_lookup(br_cfg);
      if (clr_q && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign clr_rx_rdy = clr_q;
  assign trmt       = (state_q == TX_START);
  assign tx_data    = tx_data_q;
  assign baud_goal  = baud_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_driver.sv
// +--------------------------------------------------------------------------+
// | tb_uart_echo_driver: directed vector table plus hand-written sequences   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_echo_driver;

  localparam int FIFO_DEPTH = 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_ECHO_CASE_EN
  localparam bit CASE_ON = 1'b1;
`else
  localparam bit CASE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    br_cfg;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          clr_rx_rdy;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic [13:0]   baud_goal;
  logic [CW-1:0] fifo_cnt;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  uart_echo_driver #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .baud_goal  (baud_goal),
    .fifo_cnt   (fifo_cnt),
    .overflow   (overflow)
  );

  typedef struct {
    logic [1:0]  br;
    logic [7:0]  rx;
    logic [13:0] exp_baud;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_trmt(input string nm);
    int k;
    k = 0;
    while (trmt !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    check(nm, {31'd0, trmt}, 32'd1);
  endtask

  task automatic expect_quiet(input string nm, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (trmt === 1'b1) seen = 1'b1;
    end
    check(nm, {31'd0, seen}, 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
    tick();
  endtask

  // Wait for trmt, check the byte, then model one transmitter cycle.
  task automatic xmit_one(input string nm, input logic [7:0] exp);
    wait_trmt(nm);
    check(nm, {24'd0, tx_data}, {24'd0, exp});
    tx_done = 1'b0;
    tick();
    tick();
    tick();
    tx_done = 1'b1;
    tick();
  endtask

  task automatic echo(input vec_t v);
    br_cfg = v.br;
    tick();
    tick();
    check("baud_sel", {18'd0, baud_goal}, {18'd0, v.exp_baud});
    rx_rdy  = 1'b1;
    rx_data = v.rx;
    tick();
    check("clr_pulse", {31'd0, clr_rx_rdy}, 32'd1);
    check("trmt_early", {31'd0, trmt}, 32'd0);
    // receiver drops rdy one cycle late: must not cause a second push
    tick();
    rx_rdy = 1'b0;
    check("clr_one_cycle", {31'd0, clr_rx_rdy}, 32'd0);
    check("cnt_after_push", 32'(fifo_cnt), 32'd1);
    tick();
    check("trmt_latency3", {31'd0, trmt}, 32'd1);
    check("tx_data", {24'd0, tx_data}, {24'd0, v.exp_tx});
    check("cnt_after_pop", 32'(fifo_cnt), 32'd0);
    tx_done = 1'b0;
    tick();
    check("trmt_one_cycle", {31'd0, trmt}, 32'd0);
    repeat (100) tick();
    check("baud_during_tx", {18'd0, baud_goal}, {18'd0, v.exp_baud});
    tx_done = 1'b1;
    expect_quiet("no_extra_trmt", 4);
  endtask

  initial begin
    vecs[0] = '{2'd0, 8'h41, 14'd10417, 8'h41};
    vecs[1] = '{2'd1, 8'h61, 14'd5208,  CASE_ON ? 8'h41 : 8'h61};
    vecs[2] = '{2'd2, 8'h7B, 14'd2604,  8'h7B};
    vecs[3] = '{2'd3, 8'h7A, 14'd1302,  CASE_ON ? 8'h5A : 8'h7A};
    vecs[4] = '{2'd0, 8'h60, 14'd10417, 8'h60};
    vecs[5] = '{2'd2, 8'h00, 14'd2604,  8'h00};
    vecs[6] = '{2'd1, 8'hFF, 14'd5208,  8'hFF};

    rst     = 1'b1;
    br_cfg  = 2'd2;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b1;
    repeat (3) tick();
    check("rst_baud", {18'd0, baud_goal}, 32'd5208);
    check("rst_trmt", {31'd0, trmt}, 32'd0);
    check("rst_clr", {31'd0, clr_rx_rdy}, 32'd0);
    check("rst_txdata", {24'd0, tx_data}, 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    check("baud_after_rst", {18'd0, baud_goal}, 32'd2604);

    for (int i = 0; i < 7; i++) echo(vecs[i]);

    // back-to-back with a stale tx_done=1 when ARM is entered
    send(8'h21);
    rx_rdy  = 1'b1;
    rx_data = 8'h22;
    tick();
    rx_rdy = 1'b0;
    check("b2b_first_trmt", {31'd0, trmt}, 32'd1);
    check("b2b_first_data", {24'd0, tx_data}, 32'h21);
    repeat (4) tick();
    check("stale_done_ignored", 32'(fifo_cnt), 32'd1);
    tx_done = 1'b0;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    check("b2b_gap_cycle1", {31'd0, trmt}, 32'd0);
    tick();
    check("b2b_gap_cycle2", {31'd0, trmt}, 32'd1);
    check("b2b_second_data", {24'd0, tx_data}, 32'h22);
    tx_done = 1'b0;
    tick();
    tick();
    tx_done = 1'b1;
    tick();

    // baud change while a byte is queued and in flight
    br_cfg = 2'd1;
    tick();
    tick();
    check("baud_pre", {18'd0, baud_goal}, 32'd5208);
    send(8'h55);
    br_cfg = 2'd3;
    tick();
    check("baud_hold_queued", {18'd0, baud_goal}, 32'd5208);
    tx_done = 1'b0;
    repeat (7) tick();
    check("baud_hold_wait", {18'd0, baud_goal}, 32'd5208);
    tx_done = 1'b1;
    tick();
    check("baud_hold_idle_entry", {18'd0, baud_goal}, 32'd5208);
    tick();
    check("baud_new", {18'd0, baud_goal}, 32'd1302);

    // overflow: 0x00 in flight, 0x01..0x08 fill, 0x09 dropped
    send(8'h00);
    wait_trmt("ovf_first_trmt");
    check("ovf_first_data", {24'd0, tx_data}, 32'h00);
    tx_done = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    tick();
    check("ovf_cnt_full", 32'(fifo_cnt), 32'd8);
    check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    send(8'h09);
    tick();
    check("ovf_cnt_sat", 32'(fifo_cnt), 32'd8);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    tx_done = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) xmit_one("ovf_drain", 8'(i));
    expect_quiet("ovf_dropped_absent", 10);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_cnt_empty", 32'(fifo_cnt), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    tick();

    // simultaneous push and pop with the FIFO full
    send(8'h10);
    wait_trmt("pp_first_trmt");
    tx_done = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'h10 + 8'(i));
    tick();
    tick();
    check("pp_full", 32'(fifo_cnt), 32'd8);
    tx_done = 1'b1;
    rx_rdy  = 1'b1;
    rx_data = 8'h19;
    tick();
    rx_rdy = 1'b0;
    check("pp_before", 32'(fifo_cnt), 32'd8);
    tick();
    check("pp_cnt_same", 32'(fifo_cnt), 32'd8);
    check("pp_no_ovf", {31'd0, overflow}, 32'd0);
    check("pp_trmt", {31'd0, trmt}, 32'd1);
    check("pp_head", {24'd0, tx_data}, 32'h11);
    tx_done = 1'b0;
    tick();
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    for (int i = 2; i <= 9; i++) xmit_one("pp_order", 8'h10 + 8'(i));
    tick();
    check("pp_end_cnt", 32'(fifo_cnt), 32'd0);
    check("pp_end_ovf", {31'd0, overflow}, 32'd0);

    // reset while in WAIT with a byte queued
    send(8'h33);
    wait_trmt("rw_trmt");
    tx_done = 1'b0;
    tick();
    tick();
    send(8'h34);
    check("rw_queued", 32'(fifo_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_cnt", 32'(fifo_cnt), 32'd0);
    check("rw_trmt_low", {31'd0, trmt}, 32'd0);
    check("rw_txdata", {24'd0, tx_data}, 32'd0);
    // tx_done stays low: only an IDLE FSM can start the next byte
    rx_rdy  = 1'b1;
    rx_data = 8'h35;
    tick();
    rx_rdy = 1'b0;
    tick();
    tick();
    check("rw_idle_trmt", {31'd0, trmt}, 32'd1);
    check("rw_idle_data", {24'd0, tx_data}, 32'h35);
    tick();
    tick();
    tx_done = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_echo_driver.md
# uart_echo_driver

Host-side controller for the UART's parallel interface: it consumes received bytes (`rx_rdy`/`rx_data`/`clr_rx_rdy`), buffers them in a small FIFO, and retransmits them through the transmitter handshake (`trmt`/`tx_data`/`tx_done`). It also drives the UART `baud_goal` from a 2-bit switch selection. It sits in the top level between the board I/O and the UART, forming a byte echo loop for lab bring-up.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock, 50 MHz. One clock domain; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `br_cfg`  in  2  baud select: 0=4800, 1=9600, 2=19200, 3=38400.
- `rx_rdy`  in  1  UART receiver holds a valid byte.
- `rx_data`  in  8  received byte.
- `clr_rx_rdy`  out  1  one-cycle pulse that acknowledges `rx_rdy`.
- `trmt`  out  1  one-cycle pulse that starts a transmission.
- `tx_data`  out  8  byte to transmit; stable from `trmt` until return to IDLE.
- `tx_done`  in  1  transmitter finished; held high until the next `trmt`.
- `baud_goal`  out  14  clocks per bit for the UART.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Baud table, clocks per bit = 50e6 / baud: 10417, 5208, 2604, 1302.
- `baud_goal` is a register. It loads the table entry for `br_cfg` only while the TX FSM is in IDLE and the FIFO is empty. Otherwise it holds its value, so a running transfer never changes rate.
- RX capture:
  - When `rx_rdy`=1 and `clr_rx_rdy` was 0 in the previous cycle, push `rx_data` and pulse `clr_rx_rdy` for exactly one cycle.
  - The guard prevents a double push while the receiver clears `rdy`.
- FIFO full on a push: the byte is dropped, `overflow` is set, and `clr_rx_rdy` still pulses. `overflow` clears only on `rst`.
- If a push and a pop occur in the same cycle, both succeed, including when the FIFO is full (push is accepted) and when it is empty (not possible, because a pop requires non-empty). `fifo_cnt` is unchanged in that case.
- Pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- TX FSM states: IDLE, START, ARM, WAIT.
  - IDLE → START when the FIFO is non-empty: pop the head into the `tx_data` register.
  - START: `trmt`=1 for one cycle → ARM.
  - ARM: wait for `tx_done`=0 (transmitter has accepted the byte) → WAIT.
  - WAIT: wait for `tx_done`=1 → IDLE.

## Timing
- Reset values: `clr_rx_rdy`=0, `trmt`=0, `tx_data`=0x00, `baud_goal`=5208, `fifo_cnt`=0, `overflow`=0, FSM=IDLE. Reset also empties the FIFO and aborts any in-flight transfer.
- RX path: `rx_rdy` sampled high at edge N → push and `clr_rx_rdy`=1 during cycle N+1.
- FIFO to TX: FIFO non-empty at edge M in IDLE → `trmt`=1 during cycle M+1. The pushed byte is visible to the FSM one cycle after the push.
- Minimum echo latency, from `rx_rdy` high to `trmt` high: 3 cycles.
- Back-to-back transfers: after `tx_done` rises, the next `trmt` follows at the earliest 2 cycles later (WAIT→IDLE→START).
- `tx_done` already 1 when START is entered is ignored. ARM requires a 0 first.
- `br_cfg` changes apply no earlier than 1 cycle after the conditions in Operation hold.

## Configuration
- `UART_ECHO_CASE_EN` defined: bytes 0x61–0x7A (`a`–`z`) are converted to 0x41–0x5A on the push path; all other bytes pass unchanged.
- Undefined: bytes are echoed verbatim. No conversion logic is present.

## Structure
- Package `uart_echo_pkg` holds:
  - the TX state enum `tx_state_t`;
  - the baud table constants `BAUD_4800` … `BAUD_38400` (14-bit);
  - the `CLK_FREQ_HZ` = 50_000_000 constant.
- One sub-module, `uart_echo_fifo`: synchronous FIFO with `push`, `pop`, `din`, `dout`, `full`, `empty`, `cnt`, parameterized by depth.

## Test plan
- Reset with `br_cfg`=2 → `baud_goal`=5208 during reset, then 2604 one cycle after reset deasserts; all other outputs 0.
- Single byte: `rx_rdy` with 0x41, model `tx_done` dropping 1 cycle after `trmt` and rising 100 cycles later → one `clr_rx_rdy` pulse, `trmt` 3 cycles after `rx_rdy`, `tx_data`=0x41, FSM returns to IDLE.
- With `UART_ECHO_CASE_EN`: 0x61 → `tx_data`=0x61 converted to 0x41; 0x7B → unchanged 0x7B. Without the macro, 0x61 → 0x61.
- Overflow: hold `tx_done`=0 after the first `trmt`, then send 10 bytes 0x00–0x09 → `fifo_cnt` saturates at 8, `overflow`=1, bytes 0x09 dropped; after release, `tx_data` sequence is 0x00–0x08.
- Simultaneous push and pop with the FIFO full → `fifo_cnt` stays 8, order preserved, `overflow` stays 0.
- Change `br_cfg` from 1 to 3 mid-transfer → `baud_goal` holds 5208 until the FSM is IDLE and the FIFO is empty, then becomes 1302.
- Assert `rst` while in WAIT → next cycle FSM=IDLE, `fifo_cnt`=0, `trmt`=0.
